pri_gate: RTL and testbench

- Upstream stage of the pulse integrator in the SAR receive chain.
- Takes the continuous ADC sample stream and a PRI trigger.
- After a programmable delay, emits exactly one range-gated window of samples per pulse repetition interval, with a frame marker on the last sample.
- Its output feeds the integrator's sample input, so every PRI presents a fixed-length, index-aligned frame.

---
 rtl/pri_gate_pkg.sv | 13 +
 rtl/axis_out_reg.sv | 53 +++++
 rtl/pri_gate.sv | 126 ++++++++++++
 tb/tb_pri_gate.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pri_gate_pkg.sv
// Shared constants for the PRI range gate: FSM encoding, counter width and
// the saturation limit of the missed-trigger counter.
package pri_gate_pkg;

  localparam int CNT_WIDTH_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_GATE  = 2'd2;

  localparam logic [31:0] MISSED_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream holding register. A load that arrives while an
// unaccepted beat is held is dropped and raises a sticky overrun flag.
module axis_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_last,
  output logic                  o_overrun
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_overrun;
  logic                  w_free;

  // The slot is free when empty or when the held beat leaves this cycle.
  assign w_free = ~r_valid | i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (i_load && w_free) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
        r_last  <= i_last;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
      if (i_load && !w_free) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_last    = r_last;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/pri_gate.sv
// PRI range gate: after a trigger edge, skips a latched number of valid
// samples and forwards a fixed-length frame, marking the last sample.
module pri_gate
  import pri_gate_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       trig,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  input  logic                       cfg_enable,
  input  logic [CNT_WIDTH-1:0]       cfg_delay,
  input  logic [CNT_WIDTH-1:0]       cfg_length,
  output logic [63:0]                sts_pri_count,
  output logic [31:0]                sts_missed_trig,
  output logic                       sts_overrun
);

  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 r_trig_q;
  logic [1:0]           r_state;
  logic [CNT_WIDTH-1:0] r_delay;
  logic [CNT_WIDTH-1:0] r_length;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [63:0]          r_pri_count;
  logic [31:0]          r_missed;

  logic w_trig_re;
  logic w_start;
  logic w_busy_trig;
  logic w_gate_beat;
  logic w_gate_last;

  assign w_trig_re   = trig & ~r_trig_q;
  assign w_start     = (r_state == ST_IDLE) & w_trig_re & cfg_enable & (cfg_length != '0);
  assign w_busy_trig = (r_state != ST_IDLE) & w_trig_re;
  assign w_gate_beat = (r_state == ST_GATE) & s_axis_tvalid;
  assign w_gate_last = w_gate_beat & (r_cnt == (r_length - ONE));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_trig_q <= 1'b0;
      r_state  <= ST_IDLE;
      r_delay  <= '0;
      r_length <= '0;
      r_cnt    <= '0;
    end else begin
      r_trig_q <= trig;
      case (r_state)
        ST_IDLE: begin
          // Config is latched here so mid-frame changes cannot disturb the frame.
          if (w_start) begin
            r_delay  <= cfg_delay;
            r_length <= cfg_length;
            r_cnt    <= '0;
            r_state  <= (cfg_delay != '0) ? ST_DELAY : ST_GATE;
          end
        end
        ST_DELAY: begin
          if (s_axis_tvalid) begin
            if (r_cnt == (r_delay - ONE)) begin
              r_cnt   <= '0;
              r_state <= ST_GATE;
            end else begin
              r_cnt <= r_cnt + ONE;
            end
          end
        end
        ST_GATE: begin
          if (s_axis_tvalid) begin
            if (w_gate_last) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + ONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_pri_count <= '0;
      r_missed    <= '0;
    end else begin
      if (w_gate_last) begin
        r_pri_count <= r_pri_count + 64'd1;
      end
      if (w_busy_trig && (r_missed != MISSED_SAT)) begin
        r_missed <= r_missed + 32'd1;
      end
    end
  end

  axis_out_reg #(
    .DATA_WIDTH(AXIS_DATA_WIDTH)
  ) u_out (
    .clk       (aclk),
    .rst       (areset),
    .i_load    (w_gate_beat),
    .i_data    (s_axis_tdata),
    .i_last    (w_gate_last),
    .i_ready   (m_axis_tready),
    .o_data    (m_axis_tdata),
    .o_valid   (m_axis_tvalid),
    .o_last    (m_axis_tlast),
    .o_overrun (sts_overrun)
  );

  assign s_axis_tready   = 1'b1;
  assign sts_pri_count   = r_pri_count;
  assign sts_missed_trig = r_missed;

endmodule

// File: tb/tb_pri_gate.sv
// Scoreboard bench for pri_gate: tasks push expected beats as samples are
// driven; a negedge monitor pops and compares each accepted output beat.
module tb_pri_gate;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        trig;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        cfg_enable;
  logic [15:0] cfg_delay;
  logic [15:0] cfg_length;
  logic [63:0] sts_pri_count;
  logic [31:0] sts_missed_trig;
  logic        sts_overrun;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t       sb[$];
  beat_t       mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [63:0] exp_pri = 64'd0;
  logic [31:0] exp_missed = 32'd0;

  pri_gate #(.AXIS_DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .aclk            (aclk),
    .areset          (areset),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .trig            (trig),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .cfg_enable      (cfg_enable),
    .cfg_delay       (cfg_delay),
    .cfg_length      (cfg_length),
    .sts_pri_count   (sts_pri_count),
    .sts_missed_trig (sts_missed_trig),
    .sts_overrun     (sts_overrun)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  // Beats appear the cycle after capture; cyc is -1 when timing is not checked.
  always @(negedge aclk) begin
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat data=%h last=%b cyc=%0d", m_axis_tdata, m_axis_tlast, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (m_axis_tdata !== mon_e.data || m_axis_tlast !== mon_e.last ||
            (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
          failures++;
          $display("FAIL beat got data=%h last=%b cyc=%0d expected data=%h last=%b cyc=%0d",
                   m_axis_tdata, m_axis_tlast, cyc, mon_e.data, mon_e.last, mon_e.cyc);
        end else begin
          $display("beat data=%h last=%b cyc=%0d ok", m_axis_tdata, m_axis_tlast, cyc);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic t,
                       input bit push = 1'b0, input bit last = 1'b0, input bit chk = 1'b1);
    beat_t b;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    trig          = t;
    if (push) begin
      b.data = d;
      b.last = last;
      b.cyc  = chk ? cyc + 1 : -1;
      sb.push_back(b);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 1'b0);
  endtask

  task automatic test_reset;
    areset = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; trig = 1'b0; m_axis_tready = 1'b1;
    cfg_enable = 1'b0; cfg_delay = '0; cfg_length = '0;
    repeat (3) @(posedge aclk);
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 1'b0) begin failures++; $display("FAIL rst_tlast got=%b exp=0", m_axis_tlast); end
    checks++; if (m_axis_tdata !== 32'd0) begin failures++; $display("FAIL rst_tdata got=%h exp=0", m_axis_tdata); end
    checks++; if (sts_pri_count !== 64'd0) begin failures++; $display("FAIL rst_pri got=%0d exp=0", sts_pri_count); end
    checks++; if (sts_missed_trig !== 32'd0) begin failures++; $display("FAIL rst_missed got=%0d exp=0", sts_missed_trig); end
    checks++; if (sts_overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun got=%b exp=0", sts_overrun); end
    checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL s_tready got=%b exp=1", s_axis_tready); end
    areset = 1'b0;
    idle(2);
    $display("test_reset done");
  endtask

  task automatic check_status(input string name);
    checks++;
    if (sts_pri_count !== exp_pri) begin
      failures++; $display("FAIL %s_pri got=%0d exp=%0d", name, sts_pri_count, exp_pri);
    end
    checks++;
    if (sts_missed_trig !== exp_missed) begin
      failures++; $display("FAIL %s_missed got=%0d exp=%0d", name, sts_missed_trig, exp_missed);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL %s_drain got=%0d pending exp=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_basic;
    cfg_enable = 1'b1; cfg_delay = 16'd3; cfg_length = 16'd4; m_axis_tready = 1'b1;
    drive(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 10; i++)
      drive(1'b1, i, 1'b0, (i >= 3 && i <= 6), (i == 6));
    exp_pri++;
    idle(3);
    check_status("basic");
    checks++; if (sts_overrun !== 1'b0) begin failures++; $display("FAIL basic_overrun got=%b exp=0", sts_overrun); end
    $display("test_basic done");
  endtask

  task automatic test_zero_delay_gapped;
    cfg_delay = 16'd0; cfg_length = 16'd2;
    drive(1'b0, 32'd0, 1'b1);
    drive(1'b1, 32'd10, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b0);
    drive(1'b1, 32'd11, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 32'd0, 1'b0);
    drive(1'b1, 32'd12, 1'b0);
    exp_pri++;
    idle(3);
    check_status("zero_delay");
    $display("test_zero_delay_gapped done");
  endtask

  task automatic test_backpressure;
    cfg_delay = 16'd0; cfg_length = 16'd4; m_axis_tready = 1'b1;
    drive(1'b0, 32'd0, 1'b1);
    drive(1'b1, 32'd100, 1'b0, 1'b1, 1'b0, 1'b0);
    m_axis_tready = 1'b0;
    drive(1'b1, 32'd101, 1'b0);
    checks++; if (m_axis_tdata !== 32'd100 || m_axis_tvalid !== 1'b1) begin
      failures++; $display("FAIL hold1 got=%h/%b exp=00000064/1", m_axis_tdata, m_axis_tvalid); end
    checks++; if (sts_overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b exp=1", sts_overrun); end
    drive(1'b0, 32'd0, 1'b0);
    checks++; if (m_axis_tdata !== 32'd100 || m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b0) begin
      failures++; $display("FAIL hold2 got=%h/%b/%b exp=00000064/1/0", m_axis_tdata, m_axis_tvalid, m_axis_tlast); end
    m_axis_tready = 1'b1;
    drive(1'b1, 32'd102, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'd103, 1'b0, 1'b1, 1'b1);
    exp_pri++;
    idle(3);
    check_status("backpressure");
    checks++; if (sts_overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", sts_overrun); end
    $display("test_backpressure done");
  endtask

  task automatic test_busy_trigger;
    cfg_delay = 16'd1; cfg_length = 16'd3;
    drive(1'b0, 32'd0, 1'b1);
    drive(1'b1, 32'd200, 1'b0);
    drive(1'b1, 32'd201, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 32'd202, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'd203, 1'b0, 1'b1, 1'b1);
    exp_missed++;
    exp_pri++;
    drive(1'b0, 32'd0, 1'b1);
    drive(1'b1, 32'd204, 1'b0);
    drive(1'b1, 32'd205, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'd206, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'd207, 1'b0, 1'b1, 1'b1);
    exp_pri++;
    idle(3);
    check_status("busy_trig");
    $display("test_busy_trigger done");
  endtask

  task automatic test_config_guards;
    cfg_enable = 1'b0; cfg_delay = 16'd0; cfg_length = 16'd2;
    drive(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'd250 + i, 1'b0);
    cfg_enable = 1'b1; cfg_length = 16'd0;
    drive(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'd260 + i, 1'b0);
    idle(2);
    check_status("guards");
    cfg_delay = 16'd2; cfg_length = 16'd2;
    drive(1'b0, 32'd0, 1'b1);
    cfg_delay = 16'd0; cfg_length = 16'd5; cfg_enable = 1'b0;
    drive(1'b1, 32'd300, 1'b0);
    drive(1'b1, 32'd301, 1'b0);
    drive(1'b1, 32'd302, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'd303, 1'b0, 1'b1, 1'b1);
    exp_pri++;
    drive(1'b1, 32'd304, 1'b0);
    drive(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'd310 + i, 1'b0);
    idle(2);
    check_status("midframe_cfg");
    $display("test_config_guards done");
  endtask

  task automatic test_async_reset;
    cfg_enable = 1'b1; cfg_delay = 16'd0; cfg_length = 16'd4; m_axis_tready = 1'b1;
    drive(1'b0, 32'd0, 1'b1);
    drive(1'b1, 32'd400, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'd401, 1'b0);
    #2 areset = 1'b1;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL arst_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (sts_pri_count !== 64'd0 || sts_missed_trig !== 32'd0 || sts_overrun !== 1'b0) begin
      failures++; $display("FAIL arst_sts got=%0d/%0d/%b exp=0/0/0", sts_pri_count, sts_missed_trig, sts_overrun); end
    exp_pri = 64'd0; exp_missed = 32'd0;
    s_axis_tvalid = 1'b0; trig = 1'b0;
    @(posedge aclk);
    #1 areset = 1'b0;
    cfg_delay = 16'd1; cfg_length = 16'd2;
    drive(1'b0, 32'd0, 1'b1);
    drive(1'b1, 32'd500, 1'b0);
    drive(1'b1, 32'd501, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'd502, 1'b0, 1'b1, 1'b1);
    exp_pri++;
    idle(3);
    check_status("post_reset");
    checks++; if (sts_overrun !== 1'b0) begin failures++; $display("FAIL post_reset_overrun got=%b exp=0", sts_overrun); end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_delay_gapped();
    test_backpressure();
    test_busy_trigger();
    test_config_guards();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
